// File: rtl/ahb_mtx_pkg.sv
// rtl/ahb_mtx_pkg.sv - AHB encodings, burst length helper and arbitration mode constants
package ahb_mtx_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Undefined-length INCR counts as one beat; it is held by its own hold term instead.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4, HBURST_INCR4:   burst_len = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:   burst_len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
      default:                      burst_len = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mtx_rr_pick.sv
// rtl/ahb_mtx_rr_pick.sv - combinational rotate-priority picker, first request at or after start
module ahb_mtx_rr_pick
  import ahb_mtx_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] eff,
  input  logic [IDX_W-1:0]     start,
  output logic                 valid,
  output logic [IDX_W-1:0]     index
);

  // Scan from the far end so the candidate closest to start is written last.
  always_comb begin
    int j;
    valid = 1'b0;
    index = '0;
    j     = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (eff[j]) begin
        valid = 1'b1;
        index = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ahb_mtx_arb_param.sv
// rtl/ahb_mtx_arb_param.sv - N-port output-stage arbiter, fixed or round-robin, burst and lock hold
module ahb_mtx_arb_param
  import ahb_mtx_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_W     = 3,
  parameter int ARB_MODE   = 0,
  parameter int BURST_HOLD = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 arb_hold
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [IW-1:0]        grant_q, grant_d, rr_last, rr_d, start, pick_idx;
  logic                 no_port_d, pick_valid;
  logic [4:0]           beat_cnt, len;
  logic [NUM_PORTS-1:0] eff;
  logic                 is_idle, is_busy, is_nonseq, is_seq, burst_hold;

  assign is_idle   = (HTRANSM == HTRANS_IDLE);
  assign is_busy   = (HTRANSM == HTRANS_BUSY);
  assign is_nonseq = (HTRANSM == HTRANS_NONSEQ);
  assign is_seq    = (HTRANSM == HTRANS_SEQ);
  assign len       = burst_len(HBURSTM);

  assign burst_hold = HSELM & ((is_nonseq & (len > 5'd1)) | (is_seq & (beat_cnt > 5'd1)) |
                               is_busy | ((HBURSTM == HBURST_INCR) & ~is_idle));
  assign arb_hold   = HMASTLOCKM | ((BURST_HOLD != 0) & burst_hold);

  // The current owner keeps competing while it still has a live transfer.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++)
      eff[i] = req_port[i] | ((grant_q == IW'(i)) & HSELM & ~is_idle & ~no_port);
  end

  assign start = (ARB_MODE == ARB_RR) ? ((rr_last == IW'(NUM_PORTS - 1)) ? '0 : rr_last + IW'(1))
                                      : '0;

  ahb_mtx_rr_pick #(.NUM_PORTS(NUM_PORTS), .IDX_W(IW)) u_pick (
    .eff   (eff),
    .start (start),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_comb begin
    grant_d   = grant_q;
    no_port_d = no_port;
    rr_d      = rr_last;
    if (arb_hold) begin
      no_port_d = 1'b0;
    end else if (pick_valid) begin
      grant_d   = pick_idx;
      no_port_d = 1'b0;
      if ((ARB_MODE == ARB_RR) && req_port[pick_idx]) rr_d = pick_idx;
    end else begin
      no_port_d = ~HSELM;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      grant_q  <= '0;
      no_port  <= 1'b1;
      beat_cnt <= '0;
      rr_last  <= IW'(NUM_PORTS - 1);
    end else if (HREADYM) begin
      grant_q <= grant_d;
      no_port <= no_port_d;
      rr_last <= rr_d;
      if (is_idle)                    beat_cnt <= '0;
      else if (HSELM && is_nonseq)    beat_cnt <= len - 5'd1;
      else if (is_seq && beat_cnt != 0) beat_cnt <= beat_cnt - 5'd1;
    end
  end

  assign addr_in_port = PORT_W'(grant_q);

endmodule
